sram_bytewr_pipe: RTL
=====================

Name: sram_bytewr_pipe

Overview:
- Parametrised successor of the team's 4-byte synchronous SRAM macro model.
- Single-port, byte-write-enabled word memory with configurable width, depth and read latency.
- Valid/ready request interface and a credit-protected response FIFO, so masters can backpressure responses without losing data.
- Sits between the CPU/DMA bus slave logic and the storage array; replaces direct tri-state DO/OE handling with a registered response channel.

Parameters:
ADDR_W, 10, word address width; depth = 2**ADDR_W words
BYTES, 4, bytes per word
BYTE_W, 8, bits per byte
READ_LAT, 1, cycles from request acceptance to response availability; legal values 1..4
(derived, not overridable) RSP_DEPTH = READ_LAT+1, response FIFO entries

Ports:
CK  input  1  clock, rising edge
RSTB  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request can be accepted this cycle
req_addr  input  ADDR_W  word address
req_wstrb  input  BYTES  per-byte write enable, active high; all-zero means read
req_wdata  input  BYTES*BYTE_W  write data
rsp_valid  output  1  response word available
rsp_ready  input  1  consumer takes response
rsp_rdata  output  BYTES*BYTE_W  response word
busy  output  1  scrub in progress (tied 0 when scrub compiled out)

Behaviour:
- Interface decided: one clock CK; reset RSTB is asynchronous, active-low.
- Reset values: req_ready=0 during RSTB low, rsp_valid=0, rsp_rdata=0, busy=0, outstanding count=0, FIFO pointers=0, pipeline valids=0. Memory contents are not reset.
- Accept: at rising edge where req_valid && req_ready.
- Every accepted request produces exactly one response, in order.
- Write (any strobe set): the array commits strobed bytes at the accept edge. The response carries write-through data: strobed bytes = req_wdata, unstrobed bytes = prior array contents.
- Read (strobe 0): the response is the array word.
- Read-after-write to the same address in the next cycle returns the new data; no hazard stalls.
- Pipeline: the array read is captured at the accept edge, then READ_LAT-1 further register stages, then pushed into the FIFO.
  - rsp_valid first rises in the cycle after edge t+READ_LAT-1 (READ_LAT=1 means the next cycle).
- Response channel:
  - rsp_valid = FIFO not empty; rsp_rdata = FIFO head.
  - Pop on rsp_valid && rsp_ready.
  - rsp_rdata must hold stable while rsp_valid && !rsp_ready.
- Credit counter (0..RSP_DEPTH): counts requests in the pipeline plus in the FIFO.
  - +1 on accept, -1 on pop; simultaneous accept and pop leaves it unchanged.
  - req_ready = (count < RSP_DEPTH) && !busy && RSTB. No combinational path from rsp_ready to req_ready.
- FIFO can never overflow. A push into a full FIFO is an assertion failure.
- Throughput: with rsp_ready held high, one request per cycle sustained indefinitely.
- Address wrap: addresses are ADDR_W bits only; no out-of-range case.
- Reset mid-operation: in-flight and queued responses are discarded. Writes committed before reset persist.

Optional Feature:
- Macro SRAM_SCRUB_EN.
- Defined: after RSTB deasserts, a SCRUB FSM (IDLE→SCRUB→IDLE) writes all-zero to every word, one word per cycle, addresses 0..2**ADDR_W-1.
  - busy=1 and req_ready=0 throughout.
  - busy falls after the last word's write edge; req_ready may rise the same cycle.
  - Reset during SCRUB restarts at address 0.
- Not defined: no FSM; busy tied 0; memory is uninitialised (X) until written.

Test Plan:
- READ_LAT=1: write addr 5 data 0xA1B2C3D4 strobe 4'hF, then read addr 5 next cycle → rsp_rdata 0xA1B2C3D4 one cycle after the read is accepted.
- Byte strobe: addr 5 holds 0xA1B2C3D4; write 0x11223344 strobe 4'b0101 → write response 0xA122C344; a subsequent read returns 0xA122C344.
- Backpressure, READ_LAT=2: rsp_ready=0, issue reads continuously → exactly 3 accepted, then req_ready=0. Raise rsp_ready → 3 responses in order, data stable while stalled, then streaming resumes at one per cycle.
- Throughput: rsp_ready=1, 64 back-to-back reads of addr 0..63 → 64 responses on consecutive cycles, req_ready never low after the first accept.
- Reset mid-stream: pull RSTB low with 2 responses queued → rsp_valid=0 immediately (async). After release, no stale responses appear; previously written data is still readable.
- SRAM_SCRUB_EN, ADDR_W=4: release reset → busy high for exactly 16 cycles, req_ready=0 throughout; reading any address afterwards returns 0.

Source files
------------

// File: rtl/sram_bytewr_pipe.sv
// Byte-write single-port SRAM with pipelined read and credit-protected response FIFO.
// Optional power-on scrub to zero when SRAM_SCRUB_EN is defined.
module sram_bytewr_pipe #(
    parameter int ADDR_W   = 10,
    parameter int BYTES    = 4,
    parameter int BYTE_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                    CK,
    input  logic                    RSTB,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [BYTES-1:0]        req_wstrb,
    input  logic [BYTES*BYTE_W-1:0] req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [BYTES*BYTE_W-1:0] rsp_rdata,
    output logic                    busy
);

    localparam int W         = BYTES * BYTE_W;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int RSP_DEPTH = READ_LAT + 1;
    localparam int PTR_W     = $clog2(RSP_DEPTH);
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
    } beat_t;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $error("READ_LAT must be in 1..4");
    end

    logic [W-1:0]       mem [DEPTH];
    logic [W-1:0]       rd_word;
    logic [W-1:0]       merged;
    logic               is_wr;
    logic               accept;
    logic               push;
    logic               pop;
    logic [W-1:0]       tail_d;
    logic               scrub_we;
    logic [ADDR_W-1:0]  scrub_addr;

    logic [W-1:0]       fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]   wptr_q;
    logic [PTR_W-1:0]   rptr_q;
    logic [CNT_W-1:0]   fcnt_q;
    logic [CNT_W-1:0]   cnt_q;

    assign accept  = req_valid && req_ready;
    assign is_wr   = |req_wstrb;
    assign rd_word = mem[req_addr];

    always_comb begin
        merged = rd_word;
        for (int b = 0; b < BYTES; b++) begin
            if (req_wstrb[b]) begin
                merged[b*BYTE_W +: BYTE_W] = req_wdata[b*BYTE_W +: BYTE_W];
            end
        end
    end

    // Storage is deliberately not reset so committed writes survive RSTB.
    always_ff @(posedge CK) begin
        if (scrub_we) begin
            mem[scrub_addr] <= '0;
        end else if (accept && is_wr) begin
            mem[req_addr] <= merged;
        end
    end

    if (READ_LAT == 1) begin : g_nopipe
        assign push   = accept;
        assign tail_d = merged;
    end else begin : g_pipe
        beat_t stg_q [READ_LAT-1];

        always_ff @(posedge CK or negedge RSTB) begin
            if (!RSTB) begin
                for (int i = 0; i < READ_LAT - 1; i++) begin
                    stg_q[i] <= '0;
                end
            end else begin
                stg_q[0] <= {accept, merged};
                for (int i = 1; i < READ_LAT - 1; i++) begin
                    stg_q[i] <= stg_q[i-1];
                end
            end
        end

        assign push   = stg_q[READ_LAT-2].v;
        assign tail_d = stg_q[READ_LAT-2].d;
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rsp_valid = (fcnt_q != '0);
    assign rsp_rdata = fifo_q[rptr_q];
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge CK or negedge RSTB) begin
        if (!RSTB) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= tail_d;
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    // Credits cover both pipeline and FIFO, so a push can never find it full.
    always_ff @(posedge CK or negedge RSTB) begin
        if (!RSTB) begin
            cnt_q <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign req_ready = (cnt_q < CNT_W'(RSP_DEPTH)) && !busy && RSTB;

    a_no_overflow : assert property (
        @(posedge CK) disable iff (!RSTB)
        !(push && (fcnt_q == CNT_W'(RSP_DEPTH)))
    );

`ifdef SRAM_SCRUB_EN
    typedef enum logic {
        S_IDLE,
        S_SCRUB
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] scrub_addr_q;

    always_ff @(posedge CK or negedge RSTB) begin
        if (!RSTB) begin
            state_q      <= S_SCRUB;
            busy_q       <= 1'b1;
            scrub_addr_q <= '0;
        end else begin
            case (state_q)
                S_SCRUB: begin
                    scrub_addr_q <= scrub_addr_q + 1'b1;
                    if (scrub_addr_q == '1) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q && RSTB;
    assign scrub_we   = busy;
    assign scrub_addr = scrub_addr_q;
`else
    assign busy       = 1'b0;
    assign scrub_we   = 1'b0;
    assign scrub_addr = '0;
`endif

endmodule
